// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment readback path: the segment patterns
// driven by the display LUT (active low, {g,f,e,d,c,b,a}), the digit count
// and a one-hot test for the digit select bus.
package seg7_pkg;

  localparam int NUM_DIG = 6;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h18;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // All segments dark; never a valid digit.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // True when exactly one digit-select line is active.
  function automatic logic onehot6(input logic [NUM_DIG-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_DIG; i++) begin
      cnt = cnt + int'(v[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the display LUT: maps a segment pattern back to
// its hex nibble and flags anything that is not one of the sixteen glyphs.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] iSEG,
  output logic       oKNOWN,
  output logic [3:0] oHEX
);

  // Pattern lookup; unrecognised patterns (blank included) clear oKNOWN.
  always_comb begin
    oKNOWN = 1'b1;
    oHEX   = 4'h0;
    case (iSEG)
      SEG_0:   oHEX = 4'h0;
      SEG_1:   oHEX = 4'h1;
      SEG_2:   oHEX = 4'h2;
      SEG_3:   oHEX = 4'h3;
      SEG_4:   oHEX = 4'h4;
      SEG_5:   oHEX = 4'h5;
      SEG_6:   oHEX = 4'h6;
      SEG_7:   oHEX = 4'h7;
      SEG_8:   oHEX = 4'h8;
      SEG_9:   oHEX = 4'h9;
      SEG_A:   oHEX = 4'hA;
      SEG_B:   oHEX = 4'hB;
      SEG_C:   oHEX = 4'hC;
      SEG_D:   oHEX = 4'hD;
      SEG_E:   oHEX = 4'hE;
      SEG_F:   oHEX = 4'hF;
      default: oKNOWN = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the six hex digits shown on a multiplexed 7-segment panel by
// watching the shared segment lines and the one-hot digit select. Each digit
// is captured once per dwell after the bus has been steady long enough; a
// frame is published when all six slots have been filled. oSTALE flags a
// panel that has stopped producing complete frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [6:0]             iSEG,
  input  logic [NUM_DIG-1:0]     iDIG_SEL,
  output logic [4*NUM_DIG-1:0]   oDIG,
  output logic                   oVALID,
  output logic                   oERR,
  output logic                   oSTALE
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] STAB_TOP = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TO_TOP   = TW'(TIMEOUT_CYCLES);

  // Saturating increment for the stability counter.
  function automatic logic [SW-1:0] sat_inc_stab(input logic [SW-1:0] v);
    return (v == STAB_TOP) ? v : v + 1'b1;
  endfunction

  // Saturating increment for the frame timeout counter.
  function automatic logic [TW-1:0] sat_inc_to(input logic [TW-1:0] v);
    return (v == TO_TOP) ? v : v + 1'b1;
  endfunction

  // p0/p1: two-flop synchroniser, p1 is the first usable sample.
  // p2: previous synchronised sample, for the stability comparison.
  logic [6:0]         seg_p0, seg_p1, seg_p2;
  logic [NUM_DIG-1:0] sel_p0, sel_p1, sel_p2;

  logic [SW-1:0]        stab_cnt;
  logic                 stable;
  logic                 capture;
  logic                 known;
  logic [3:0]           hex;
  logic [NUM_DIG-1:0]   mask;
  logic [NUM_DIG-1:0]   mask_next;
  logic [4*NUM_DIG-1:0] shadow;
  logic [4*NUM_DIG-1:0] merged;
  logic                 frame_done;
  logic [TW-1:0]        to_cnt;
  logic [TW-1:0]        to_next;

  // Synchronise the asynchronous panel lines and keep one sample of history.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      seg_p0 <= '0;
      seg_p1 <= '0;
      seg_p2 <= '0;
      sel_p0 <= '0;
      sel_p1 <= '0;
      sel_p2 <= '0;
    end else begin
      seg_p0 <= iSEG;
      seg_p1 <= seg_p0;
      seg_p2 <= seg_p1;
      sel_p0 <= iDIG_SEL;
      sel_p1 <= sel_p0;
      sel_p2 <= sel_p1;
    end
  end

  // A sample counts toward a dwell only when nothing moved and a single digit is selected.
  always_comb begin
    stable  = (seg_p1 == seg_p2) && (sel_p1 == sel_p2) && onehot6(sel_p1);
    capture = stable && (stab_cnt == STAB_PRE);
  end

  // Stability counter; saturation keeps a long dwell from capturing twice.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stab_cnt <= '0;
    end else if (!stable) begin
      stab_cnt <= '0;
    end else begin
      stab_cnt <= sat_inc_stab(stab_cnt);
    end
  end

  seg7_pattern_decode u_decode (
    .iSEG   (seg_p1),
    .oKNOWN (known),
    .oHEX   (hex)
  );

  // Shadow with the digit being captured merged in, and the resulting frame status.
  always_comb begin
    merged = shadow;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (sel_p1[i]) begin
        merged[i*4 +: 4] = hex;
      end
    end
    mask_next  = mask | sel_p1;
    frame_done = capture && known && (mask_next == {NUM_DIG{1'b1}});
  end

  // Capture into the shadow, publish full frames and flag unknown glyphs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      shadow <= '0;
      mask   <= '0;
      oDIG   <= '0;
      oVALID <= 1'b0;
      oERR   <= 1'b0;
    end else begin
      oVALID <= frame_done;
      oERR   <= capture && !known;
      if (capture && known) begin
        shadow <= merged;
        if (frame_done) begin
          oDIG <= merged;
          mask <= '0;
        end else begin
          mask <= mask_next;
        end
      end
    end
  end

  // A completed frame restarts the timeout even if it has already expired.
  always_comb begin
    to_next = frame_done ? '0 : sat_inc_to(to_cnt);
  end

  // Timeout counter with oSTALE registered alongside it.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      to_cnt <= '0;
      oSTALE <= 1'b0;
    end else begin
      to_cnt <= to_next;
      oSTALE <= (to_next == TO_TOP);
    end
  end

endmodule
